// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, INCR-burst line refill,
// single-beat bypass for the device region (paddr[31]==0), fence_i invalidate-all.
module icache_direct #(
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        fence_i,
    output logic        creq_valid,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_len,
    output logic        creq_burst,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);
    localparam int unsigned OFF = $clog2(LINE_BEATS * 8);
    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned BW  = $clog2(LINE_BEATS);
    localparam int unsigned TW  = 32 - OFF - IDX;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_BYPASS} state_t;
    state_t r_state, w_next;

    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [63:0]      r_data [LINES*LINE_BEATS];
    logic [63:2]      r_addr;
    logic [BW-1:0]    r_cnt;
    logic             r_flush_pend;
    logic             r_byp_ok;
    logic [31:0]      r_byp_word;

    logic [IDX-1:0] w_idx, w_ridx;
    logic [BW-1:0]  w_beat;
    logic [TW-1:0]  w_tag;
    logic [63:0]    w_line;
    logic           w_hit, w_byp_match, w_flush;
    logic           w_unused;

    assign w_idx       = ireq_addr[OFF+IDX-1:OFF];
    assign w_beat      = ireq_addr[OFF-1:3];
    assign w_tag       = ireq_addr[31:OFF+IDX];
    assign w_ridx      = r_addr[OFF+IDX-1:OFF];
    assign w_line      = r_data[{w_idx, w_beat}];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_byp_match = r_byp_ok && ireq_valid && (ireq_addr[63:2] == r_addr);
    assign w_flush     = fence_i || r_flush_pend;
    assign w_unused    = ^ireq_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        creq_valid    = 1'b0;
        creq_addr     = '0;
        creq_len      = '0;
        creq_burst    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ireq_valid) begin
                    // A completed bypass is only delivered to the request that issued it.
                    if (w_byp_match) begin
                        iresp_addr_ok = 1'b1;
                        iresp_data_ok = 1'b1;
                        iresp_data    = r_byp_word;
                    end else if (ireq_addr[31]) begin
                        if (w_hit) begin
                            iresp_addr_ok = 1'b1;
                            iresp_data_ok = 1'b1;
                            iresp_data    = ireq_addr[2] ? w_line[63:32] : w_line[31:0];
                        end else begin
                            w_next = S_REFILL;
                        end
                    end else begin
                        w_next = S_BYPASS;
                    end
                end
            end
            S_REFILL: begin
                creq_valid = 1'b1;
                creq_addr  = {r_addr[63:OFF], {OFF{1'b0}}};
                creq_len   = 8'(LINE_BEATS - 1);
                creq_burst = 1'b1;
                if (cresp_ready && cresp_last) w_next = S_IDLE;
            end
            S_BYPASS: begin
                creq_valid = 1'b1;
                creq_addr  = {r_addr[63:3], 3'b000};
                if (cresp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_byp_ok     <= 1'b0;
            r_byp_word   <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
        end else begin
            r_byp_ok <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fence_i) r_valid <= '0;
                    if (w_next != S_IDLE) begin
                        r_addr <= ireq_addr[63:2];
                        r_cnt  <= '0;
                    end
                end
                S_REFILL: begin
                    if (fence_i) r_flush_pend <= 1'b1;
                    if (cresp_ready) begin
                        r_cnt <= r_cnt + BW'(1);
                        if (cresp_last) begin
                            if (w_flush) r_valid <= '0;
                            else         r_valid[w_ridx] <= 1'b1;
                            r_flush_pend <= 1'b0;
                        end
                    end
                end
                S_BYPASS: begin
                    if (fence_i) r_flush_pend <= 1'b1;
                    if (cresp_ready) begin
                        r_byp_word   <= r_addr[2] ? cresp_data[63:32] : cresp_data[31:0];
                        r_byp_ok     <= 1'b1;
                        r_flush_pend <= 1'b0;
                        if (w_flush) r_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage has no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (reset && r_state == S_REFILL && cresp_ready) begin
            r_data[{w_ridx, r_cnt}] <= cresp_data;
            if (cresp_last) r_tag[w_ridx] <= r_addr[31:OFF+IDX];
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetches
// checked against a line-residency model and a fixed memory image.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = '0;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fence_i = 1'b0;
    logic        creq_valid;
    logic [63:0] creq_addr;
    logic [7:0]  creq_len;
    logic        creq_burst;
    logic        cresp_ready = 1'b0;
    logic        cresp_last = 1'b0;
    logic [63:0] cresp_data = '0;

    icache_direct #(.LINES(16), .LINE_BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .fence_i(fence_i),
        .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_len(creq_len), .creq_burst(creq_burst),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    // Memory image: fixed content per 8-byte beat address.
    function automatic logic [63:0] mem64(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        if (a[31:6] == 26'h200_0000) return {2{32'h11 + 32'(a[5:3])}};
        if (a[31:3] == 29'h0800_0000) return 64'hAABBCCDD_11223344;
        return {lo ^ 32'hDEADBEEF, lo * 32'h9E37_79B1 + 32'h1234_5677};
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [63:0] b;
        b = mem64({a[63:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    // Cache model: which 64-byte line (addr[31:6]) each index holds.
    bit          m_valid [16];
    logic [25:0] m_key   [16];

    function automatic bit model_hit(input logic [63:0] a);
        return a[31] && m_valid[a[9:6]] && (m_key[a[9:6]] == a[31:6]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    // Memory-side responder.
    bit          gap_en = 0;
    bit          in_txn = 0;
    int          req_cnt = 0;
    int          rsp_beats = 0;
    int          last_cyc = 0;
    logic [63:0] rq_addr = '0;
    logic [7:0]  rq_len = '0;
    logic        rq_burst = 1'b0;

    initial forever begin
        @(negedge clk);
        #1;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        if (!reset) begin
            in_txn = 0;
        end else if (creq_valid) begin
            if (!in_txn) begin
                in_txn = 1; rq_addr = creq_addr; rq_len = creq_len; rq_burst = creq_burst;
                req_cnt++; rsp_beats = 0;
            end
            if (!gap_en || $urandom_range(0, 3) != 0) begin
                cresp_ready = 1'b1;
                cresp_data  = mem64(rq_addr + 64'(rsp_beats) * 8);
                cresp_last  = (rsp_beats == int'(rq_len));
                rsp_beats++;
                if (cresp_last) begin in_txn = 0; last_cyc = cyc; end
            end
        end
    end

    task automatic fetch(input logic [63:0] a, output logic [31:0] d, output int n,
                         output int nreq, output int okc, output bit to);
        int r0;
        r0 = req_cnt; to = 1; n = 0; d = '0; okc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ireq_valid = 1'b1; ireq_addr = a;
            #2;
            n++;
            if (iresp_data_ok === 1'b1) begin d = iresp_data; okc = cyc; to = 0; break; end
        end
        nreq = req_cnt - r0;
        @(negedge clk);
        ireq_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); ireq_valid = 1'b0; fence_i = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        model_clear();
        @(negedge clk); #2;
        checks++; if (creq_valid !== 1'b0) begin errors++; $display("FAIL reset_creq_valid: got %b want 0", creq_valid); end
        checks++; if (iresp_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b want 0", iresp_addr_ok); end
        checks++; if (iresp_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b want 0", iresp_data_ok); end
        checks++; if (iresp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", iresp_data); end
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; int n, nreq, okc; bit to;
        fetch(64'h8000_0000, d, n, nreq, okc, to);
        m_valid[0] = 1; m_key[0] = 26'h200_0000;
        checks++; if (to) begin errors++; $display("FAIL cold_timeout: got timeout want data_ok"); end
        checks++; if (rq_addr !== 64'h8000_0000) begin errors++; $display("FAIL cold_creq_addr: got %h want 80000000", rq_addr); end
        checks++; if (rq_len !== 8'd7 || rq_burst !== 1'b1) begin errors++; $display("FAIL cold_creq_len_burst: got %0d/%b want 7/1", rq_len, rq_burst); end
        checks++; if (d !== 32'h0000_0011) begin errors++; $display("FAIL cold_data: got %h want 00000011", d); end
        checks++; if (n != 10) begin errors++; $display("FAIL cold_latency: got %0d want 10", n); end
        checks++; if (okc - last_cyc != 1) begin errors++; $display("FAIL cold_after_last: got %0d want 1", okc - last_cyc); end
    endtask

    task automatic test_hit_in_line();
        logic [31:0] d; int n, nreq, okc; bit to;
        @(negedge clk); ireq_valid = 1'b1; ireq_addr = 64'h8000_003C; #2;
        checks++; if (iresp_addr_ok !== 1'b1 || iresp_data_ok !== 1'b1) begin errors++; $display("FAIL hit_same_cycle: got %b%b want 11", iresp_addr_ok, iresp_data_ok); end
        checks++; if (creq_valid !== 1'b0) begin errors++; $display("FAIL hit_no_creq: got %b want 0", creq_valid); end
        fetch(64'h8000_003C, d, n, nreq, okc, to);
        checks++; if (d !== 32'h0000_0018 || n != 1 || nreq != 0) begin errors++; $display("FAIL hit_data: got %h n=%0d req=%0d want 00000018 n=1 req=0", d, n, nreq); end
    endtask

    task automatic test_conflict();
        logic [31:0] d; int n, nreq, okc; bit to;
        fetch(64'h8000_0400, d, n, nreq, okc, to);
        checks++; if (nreq != 1 || d !== exp_word(64'h8000_0400)) begin errors++; $display("FAIL conflict_load: got req=%0d d=%h want req=1 d=%h", nreq, d, exp_word(64'h8000_0400)); end
        fetch(64'h8000_0000, d, n, nreq, okc, to);
        checks++; if (nreq != 1 || d !== 32'h11) begin errors++; $display("FAIL conflict_evict: got req=%0d d=%h want req=1 d=00000011", nreq, d); end
        m_key[0] = 26'h200_0000;
    endtask

    task automatic test_bypass();
        logic [31:0] d; int n, nreq, okc; bit to;
        fetch(64'h4000_0004, d, n, nreq, okc, to);
        checks++; if (to || d !== 32'hAABBCCDD) begin errors++; $display("FAIL byp_data: got %h to=%0d want aabbccdd", d, to); end
        checks++; if (rq_addr !== 64'h4000_0000 || rq_len !== 8'd0 || rq_burst !== 1'b0) begin errors++; $display("FAIL byp_creq: got %h/%0d/%b want 40000000/0/0", rq_addr, rq_len, rq_burst); end
        fetch(64'h4000_0004, d, n, nreq, okc, to);
        checks++; if (nreq != 1) begin errors++; $display("FAIL byp_repeat_req: got %0d want 1", nreq); end
    endtask

    task automatic test_fence();
        logic [31:0] d; int n, nreq, okc, r0; bit to, fenced, got;
        @(negedge clk); ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; fence_i = 1'b1; #2;
        checks++; if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h11) begin errors++; $display("FAIL fence_same_cycle_hit: got %b/%h want 1/00000011", iresp_data_ok, iresp_data); end
        idle(1);
        model_clear();
        fetch(64'h8000_0000, d, n, nreq, okc, to);
        checks++; if (nreq != 1 || d !== 32'h11) begin errors++; $display("FAIL fence_idle_miss: got req=%0d d=%h want req=1 d=00000011", nreq, d); end
        r0 = req_cnt; got = 0; fenced = 0; d = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); ireq_valid = 1'b1; ireq_addr = 64'h8000_0044; fence_i = 1'b0; #2;
            if (iresp_data_ok === 1'b1) begin got = 1; d = iresp_data; end
            else if (!fenced && in_txn && rsp_beats == 3) begin fence_i = 1'b1; fenced = 1; end
        end
        idle(1);
        model_clear();
        m_valid[1] = 1; m_key[1] = 26'h200_0001;
        checks++; if (!got || d !== exp_word(64'h8000_0044)) begin errors++; $display("FAIL fence_mid_data: got %h ok=%0d want %h", d, got, exp_word(64'h8000_0044)); end
        checks++; if (req_cnt - r0 != 2) begin errors++; $display("FAIL fence_mid_rerefill: got %0d want 2", req_cnt - r0); end
        fetch(64'h8000_0000, d, n, nreq, okc, to);
        m_valid[0] = 1; m_key[0] = 26'h200_0000;
        checks++; if (nreq != 1) begin errors++; $display("FAIL fence_mid_flush_all: got req=%0d want 1", nreq); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d; int n, nreq, okc; bit to, hit3;
        hit3 = 0;
        for (int i = 0; i < 100 && !hit3; i++) begin
            @(negedge clk); ireq_valid = 1'b1; ireq_addr = 64'h8000_2000; #2;
            if (in_txn && rsp_beats == 3) begin reset = 1'b0; ireq_valid = 1'b0; hit3 = 1; end
        end
        checks++; if (!hit3) begin errors++; $display("FAIL rst_mid_reach_beat3: got timeout want beat 3"); end
        @(negedge clk); #2;
        checks++; if (creq_valid !== 1'b0 || iresp_addr_ok !== 1'b0 || iresp_data_ok !== 1'b0 || iresp_data !== 32'h0)
            begin errors++; $display("FAIL rst_mid_outputs: got %b%b%b/%h want 000/0", creq_valid, iresp_addr_ok, iresp_data_ok, iresp_data); end
        @(negedge clk); reset = 1'b1;
        model_clear();
        fetch(64'h8000_0000, d, n, nreq, okc, to);
        checks++; if (nreq != 1 || d !== 32'h11) begin errors++; $display("FAIL rst_mid_miss: got req=%0d d=%h want req=1 d=00000011", nreq, d); end
        fetch(64'h8000_2000, d, n, nreq, okc, to);
        checks++; if (nreq != 1 || d !== exp_word(64'h8000_2000)) begin errors++; $display("FAIL rst_mid_partial: got req=%0d d=%h want req=1 d=%h", nreq, d, exp_word(64'h8000_2000)); end
        m_valid[0] = 1; m_key[0] = 26'h200_0080;
    endtask

    task automatic test_abandon();
        logic [31:0] d; int n, nreq, okc; bit to, done;
        for (int k = 0; k < 2; k++) begin
            logic [63:0] a;
            a = (k == 0) ? 64'h8000_1088 : 64'h0000_1234;
            for (int i = 0; i < 2; i++) begin @(negedge clk); ireq_valid = 1'b1; ireq_addr = a; end
            done = 0;
            for (int i = 0; i < 300 && !done; i++) begin
                @(negedge clk); ireq_valid = 1'b0; #2;
                if (!in_txn && creq_valid === 1'b0) done = 1;
            end
            checks++; if (!done) begin errors++; $display("FAIL abandon_complete_%0d: got timeout want idle", k); end
            idle(2);
            fetch(a, d, n, nreq, okc, to);
            checks++; if (nreq != k || d !== exp_word(a)) begin errors++; $display("FAIL abandon_reuse_%0d: got req=%0d d=%h want req=%0d d=%h", k, nreq, d, k, exp_word(a)); end
        end
        m_valid[2] = 1; m_key[2] = 26'h200_0042;
    endtask

    task automatic test_random();
        logic [31:0] d; int n, nreq, okc; bit to, h;
        logic [63:0] a;
        gap_en = 1;
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clk); ireq_valid = 1'b0; fence_i = 1'b1;
                @(negedge clk); fence_i = 1'b0;
                model_clear();
                continue;
            end
            if (r <= 2) a = {32'($urandom), 1'b0, 31'($urandom)};
            else a = {($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 32'h1FFF))};
            h = model_hit(a);
            fetch(a, d, n, nreq, okc, to);
            checks++;
            if (to || d !== exp_word(a) || nreq != (h ? 0 : 1) || (h && n != 1)) begin
                errors++;
                $display("FAIL rand_fetch: addr=%h got d=%h req=%0d n=%0d to=%0d want d=%h hit=%0d", a, d, nreq, n, to, exp_word(a), h);
            end else if (!h) begin
                checks++;
                if (rq_addr !== (a[31] ? {a[63:6], 6'b0} : {a[63:3], 3'b0}) || rq_len !== (a[31] ? 8'd7 : 8'd0)
                    || rq_burst !== a[31] || okc - last_cyc != 1) begin
                    errors++;
                    $display("FAIL rand_creq: addr=%h got %h/%0d/%b lat=%0d", a, rq_addr, rq_len, rq_burst, okc - last_cyc);
                end
            end
            if (a[31]) begin m_valid[a[9:6]] = 1; m_key[a[9:6]] = a[31:6]; end
        end
        gap_en = 0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_in_line();
        test_conflict();
        test_bypass();
        test_fence();
        test_reset_mid_refill();
        test_abandon();
        test_random();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch port (ireq/iresp) and the memory-side burst bus.
- Hits return in the same cycle the request is seen.
- Misses refill one full line with an INCR burst.
- Device region (paddr[31]==0) bypasses the cache with a single-beat read.
- fence_i invalidates every line.

Parameters:
- LINES, 16, number of lines; power of 2, ≥2.
- LINE_BEATS, 8, 64-bit beats per line; power of 2, ≥2. Line size = LINE_BEATS*8 bytes.
- Derived: OFF=log2(LINE_BEATS*8), IDX=log2(LINES), tag = addr[31:OFF+IDX].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- ireq_valid  in  1  fetch request valid; core holds valid and addr stable until data_ok
- ireq_addr  in  64  fetch byte address; bits [1:0] ignored
- iresp_addr_ok  out  1  request accepted
- iresp_data_ok  out  1  iresp_data valid
- iresp_data  out  32  instruction word
- fence_i  in  1  one-cycle pulse: invalidate all lines
- creq_valid  out  1  memory read request valid
- creq_addr  out  64  memory read address
- creq_len  out  8  beats-1 (LINE_BEATS-1 for refill, 0 for bypass)
- creq_burst  out  1  1=INCR burst, 0=fixed single
- cresp_ready  in  1  beat valid this cycle
- cresp_last  in  1  final beat of the transaction
- cresp_data  in  64  beat data

Behaviour:
- Storage: per line a valid bit, a tag, and LINE_BEATS×64-bit data. Reset clears all valid bits only; data and tag are don't-care.
- Reset values: state=IDLE, creq_valid=0, iresp_addr_ok=0, iresp_data_ok=0, iresp_data=0, pending_flush=0.
- States: IDLE, REFILL, BYPASS.
- IDLE, ireq_valid=1, cached address (addr[31]=1):
  - hit (valid && tag match) → addr_ok=data_ok=1 combinationally in the same cycle.
  - iresp_data = word at beat addr[OFF-1:3], half selected by addr[2] (1 = upper 32 bits).
- IDLE, cached miss → next state REFILL; latch index and tag.
- IDLE, addr[31]=0 → next state BYPASS; latch addr.
- In IDLE with no request, addr_ok=data_ok=0 and iresp_data=0.
- REFILL:
  - creq_valid=1, creq_addr={addr[63:OFF], OFF'b0}, creq_len=LINE_BEATS-1, creq_burst=1.
  - Beat counter starts at 0. Each cycle with cresp_ready=1 writes cresp_data to beat[counter] of the latched line, then counter++.
  - On cresp_ready && cresp_last: write the tag; set valid=1 unless a flush is pending; return to IDLE.
  - The request re-looks-up the next cycle; a 1-cycle hit follows.
  - creq_valid deasserts the cycle after last.
- BYPASS:
  - creq_valid=1, creq_addr={addr[63:3],3'b0}, creq_len=0, creq_burst=0.
  - On cresp_ready: register the selected 32-bit half (by addr[2]); go to IDLE.
  - In the next cycle, assert addr_ok=data_ok=1 with the registered word if ireq_valid is still high with the same addr. Bypass data is never written to the cache.
- Abandoned request: if ireq_valid drops during REFILL or BYPASS, the bus transaction still completes (no abort). Refill data is still installed; bypass data is discarded.
- fence_i in IDLE: all valid bits clear at the next edge. A lookup in the same cycle still uses the old contents (hit allowed).
- fence_i during REFILL/BYPASS: set pending_flush. At completion, clear all valid bits; the just-refilled line stays invalid. pending_flush clears.
- Reset mid-REFILL: return to IDLE and clear valid bits. The memory side must also be reset; no partial line is ever marked valid.
- Index wrap: LINES-1 → 0 follows address bits naturally. Beat counter width is log2(LINE_BEATS); last is taken from cresp_last, not the counter.
- Conflict: a refill of index i overwrites the old line unconditionally (no write-back; read-only).

Test Plan:
- Cold miss: reset, ireq addr 0x8000_0000 → creq addr 0x8000_0000, len 7, burst 1. Supply beats 0..7 = 0x11..18 replicated. One cycle after last, data_ok=1 with data=0x0000_0011 (low half of beat 0); total latency = 8 beats + 2 cycles.
- Hit in line: after the refill above, addr 0x8000_003C → same-cycle addr_ok=data_ok=1, data = upper half of beat 7; no creq_valid.
- Conflict eviction (LINES=16, OFF=6): load 0x8000_0000, then 0x8000_0400 (same index 0, different tag) → refill. Re-access 0x8000_0000 → miss again.
- Bypass: addr 0x4000_0004 → creq len 0, burst 0, addr 0x4000_0000. Beat 0xAABBCCDD_11223344 → data 0xAABBCCDD. A repeat access issues creq again.
- fence_i: after a hit on 0x8000_0000, pulse fence_i in IDLE → next access misses. Pulse fence_i mid-refill → that line is not valid afterwards; the following access refills again.
- Reset mid-refill: assert reset (0) at beat 3 → all outputs return to reset values. After release, 0x8000_0000 misses.
